// File: rtl/fu_result_buffer.sv
// Output-side result FIFO for one multi-cycle functional unit. Holds completed
// results in order and requests writeback from the execute-stage priority mux.
module fu_result_buffer #(
  parameter int          DATA_W  = 32,
  parameter int          DEPTH   = 2,
  parameter logic [3:0]  UNIT_ID = 4'b0011
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       fu_valid_i,
  output logic                       fu_ready_o,
  input  logic [DATA_W-1:0]          fu_result_i,
  input  logic [4:0]                 fu_rd_i,
  input  logic                       fu_reg_write_i,
  input  logic                       fu_FP_reg_write_i,
  input  logic                       flush_i,
  output logic                       req_o,
  output logic [3:0]                 unit_id_o,
  input  logic                       grant_i,
  output logic [DATA_W-1:0]          result_o,
  output logic [4:0]                 rd_o,
  output logic                       reg_write_o,
  output logic                       FP_reg_write_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [4:0]        rd;
    logic              reg_write;
    logic              fp_reg_write;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  // Ready depends only on the registered count, so there is no path from grant_i.
  assign fu_ready_o = (count != CNT_W'(DEPTH));
  assign req_o      = (count != '0);
  assign push       = fu_valid_i && fu_ready_o;
  assign pop        = req_o && grant_i;
  assign unit_id_o  = UNIT_ID;
  assign count_o    = count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage carries no reset; an empty buffer masks it at the outputs.
  always_ff @(posedge clk) begin
    if (reset_n && !flush_i && push) begin
      mem[wr_ptr] <= '{result:       fu_result_i,
                       rd:           fu_rd_i,
                       reg_write:    fu_reg_write_i,
                       fp_reg_write: fu_FP_reg_write_i};
    end
  end

  always_comb begin
    head = req_o ? mem[rd_ptr] : '0;
    result_o       = head.result;
    rd_o           = head.rd;
    reg_write_o    = head.reg_write;
    FP_reg_write_o = head.fp_reg_write;
  end

endmodule

// File: tb/tb_fu_result_buffer.sv
// Directed bench for fu_result_buffer (DEPTH=2): reset, ordering, fill,
// concurrent push/pop, wrap-around, flush and mid-operation reset.
module tb_fu_result_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              fu_valid_i;
  logic              fu_ready_o;
  logic [DATA_W-1:0] fu_result_i;
  logic [4:0]        fu_rd_i;
  logic              fu_reg_write_i;
  logic              fu_FP_reg_write_i;
  logic              flush_i;
  logic              req_o;
  logic [3:0]        unit_id_o;
  logic              grant_i;
  logic [DATA_W-1:0] result_o;
  logic [4:0]        rd_o;
  logic              reg_write_o;
  logic              FP_reg_write_o;
  logic [1:0]        count_o;

  int errs   = 0;
  int checks = 0;

  fu_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .UNIT_ID(4'b0011)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .fu_valid_i        (fu_valid_i),
    .fu_ready_o        (fu_ready_o),
    .fu_result_i       (fu_result_i),
    .fu_rd_i           (fu_rd_i),
    .fu_reg_write_i    (fu_reg_write_i),
    .fu_FP_reg_write_i (fu_FP_reg_write_i),
    .flush_i           (flush_i),
    .req_o             (req_o),
    .unit_id_o         (unit_id_o),
    .grant_i           (grant_i),
    .result_o          (result_o),
    .rd_o              (rd_o),
    .reg_write_o       (reg_write_o),
    .FP_reg_write_o    (FP_reg_write_o),
    .count_o           (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [31:0] d, input logic [4:0] rd,
                          input logic rw, input logic fw);
    fu_valid_i        = v;
    fu_result_i       = d;
    fu_rd_i           = rd;
    fu_reg_write_i    = rw;
    fu_FP_reg_write_i = fw;
  endtask

  initial begin
    reset_n = 1'b0;
    flush_i = 1'b0;
    grant_i = 1'b0;
    set_push(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);

    // Reset and idle
    step();
    step();
    chk("rst_req",    req_o,      0);
    chk("rst_ready",  fu_ready_o, 1);
    chk("rst_count",  count_o,    0);
    chk("rst_result", result_o,   0);
    chk("rst_rd",     rd_o,       0);
    chk("rst_unit",   unit_id_o,  4'b0011);
    reset_n = 1'b1;
    step();
    chk("idle_req",  req_o,     0);
    chk("idle_unit", unit_id_o, 4'b0011);

    // Single result held without grant, then granted
    set_push(1'b1, 32'hDEADBEEF, 5'd7, 1'b1, 1'b0);
    step();
    set_push(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("one_req",    req_o,       1);
    chk("one_result", result_o,    32'hDEADBEEF);
    chk("one_rd",     rd_o,        7);
    chk("one_rw",     reg_write_o, 1);
    chk("one_fw",     FP_reg_write_o, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_result", result_o, 32'hDEADBEEF);
      chk("hold_req",    req_o,    1);
    end
    grant_i = 1'b1;
    step();
    grant_i = 1'b0;
    chk("pop_req",    req_o,    0);
    chk("pop_result", result_o, 0);
    chk("pop_rd",     rd_o,     0);
    chk("pop_count",  count_o,  0);

    // Grant on empty buffer is ignored
    grant_i = 1'b1;
    step();
    grant_i = 1'b0;
    chk("empty_grant_count", count_o, 0);
    chk("empty_grant_ready", fu_ready_o, 1);

    // Fill, reject third, drain in order
    set_push(1'b1, 32'h1, 5'd3, 1'b1, 1'b0);
    step();
    set_push(1'b1, 32'h2, 5'd9, 1'b0, 1'b1);
    step();
    chk("full_count", count_o,    2);
    chk("full_ready", fu_ready_o, 0);
    set_push(1'b1, 32'h3, 5'd4, 1'b1, 1'b0);
    step();
    set_push(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("reject_count", count_o,  2);
    chk("order_1",      result_o, 32'h1);
    chk("order_1_rd",   rd_o,     3);
    grant_i = 1'b1;
    step();
    chk("order_2",      result_o, 32'h2);
    chk("order_2_rd",   rd_o,     9);
    chk("order_2_fw",   FP_reg_write_o, 1);
    chk("order_2_rw",   reg_write_o, 0);
    chk("order_2_cnt",  count_o,  1);
    step();
    grant_i = 1'b0;
    chk("drained_req",  req_o,    0);

    // Concurrent push and pop keeps count
    set_push(1'b1, 32'hA, 5'd1, 1'b1, 1'b0);
    step();
    set_push(1'b1, 32'hB, 5'd2, 1'b1, 1'b0);
    grant_i = 1'b1;
    step();
    set_push(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("conc_count",  count_o,  1);
    chk("conc_result", result_o, 32'hB);
    step();
    grant_i = 1'b0;
    chk("conc_drain",  count_o,  0);

    // Wrap-around
    for (int i = 0; i < 5; i++) begin
      set_push(1'b1, 32'(i), 5'(i + 10), 1'b1, 1'b0);
      step();
      set_push(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
      chk("wrap_result", result_o, i);
      chk("wrap_count",  count_o,  1);
      grant_i = 1'b1;
      step();
      grant_i = 1'b0;
      chk("wrap_empty",  count_o,  0);
    end

    // Flush with concurrent push and grant
    set_push(1'b1, 32'h11, 5'd5, 1'b1, 1'b0);
    step();
    set_push(1'b1, 32'h22, 5'd6, 1'b1, 1'b0);
    step();
    chk("pre_flush_count", count_o, 2);
    set_push(1'b1, 32'hC, 5'd8, 1'b1, 1'b0);
    flush_i = 1'b1;
    grant_i = 1'b1;
    #1;
    chk("flush_ready_cycle", fu_ready_o, 0);
    step();
    flush_i = 1'b0;
    grant_i = 1'b0;
    set_push(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("flush_count",  count_o,  0);
    chk("flush_req",    req_o,    0);
    chk("flush_result", result_o, 0);
    set_push(1'b1, 32'hD, 5'd2, 1'b0, 1'b0);
    step();
    set_push(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("post_flush_result", result_o, 32'hD);
    chk("post_flush_req",    req_o,    1);
    chk("post_flush_count",  count_o,  1);
    chk("post_flush_rw",     reg_write_o, 0);

    // Mid-operation reset
    set_push(1'b1, 32'hE, 5'd3, 1'b1, 1'b0);
    step();
    set_push(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    reset_n = 1'b0;
    step();
    chk("midrst_count",  count_o,    0);
    chk("midrst_req",    req_o,      0);
    chk("midrst_ready",  fu_ready_o, 1);
    chk("midrst_result", result_o,   0);
    reset_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
